// File: rtl/dmem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared definitions for the MA-stage data-memory access controller:
//   - controller state enum
//   - RV32 load funct3 codes and store size codes
//   - word-granular memory strobe encodings
//   - store-merge helper used for sub-word read-modify-write
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  // Load funct3 codes (mem_read[2:0])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size codes (mem_write[1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // The memory only understands whole-word transfers.
  localparam logic [3:0] DMEM_RD_WORD = 4'b1010;
  localparam logic [2:0] DMEM_WR_WORD = 3'b110;
  localparam logic [3:0] DMEM_RD_NONE = 4'b0000;
  localparam logic [2:0] DMEM_WR_NONE = 3'b000;

  // Insert the right-justified store data into the addressed lane of a word.
  // Word-size or reserved sizes return the original word unchanged.
  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] merged;
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'b00:   merged[7:0]   = data[7:0];
          2'b01:   merged[15:8]  = data[7:0];
          2'b10:   merged[23:16] = data[7:0];
          2'b11:   merged[31:24] = data[7:0];
          default: merged        = word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged[31:16] = data[15:0];
        end else begin
          merged[15:0] = data[15:0];
        end
      end
      default: merged = word;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Word-only data-memory bus between the access controller and the memory.
//   dmem_read      controller -> memory  read strobe  ({1,010} active, 0 idle)
//   dmem_write     controller -> memory  write strobe ({1,10} active, 0 idle)
//   dmem_address   controller -> memory  word-aligned byte address
//   dmem_writedata controller -> memory  full word to write
//   dmem_readdata  memory -> controller  word returned by memory
//   dmem_busywait  memory -> controller  memory not ready, hold current phase
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;

  logic [3:0]  dmem_read;
  logic [2:0]  dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_writedata;
  logic [31:0] dmem_readdata;
  logic        dmem_busywait;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_address,
    output dmem_writedata,
    input  dmem_readdata,
    input  dmem_busywait
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_address,
    input  dmem_writedata,
    output dmem_readdata,
    output dmem_busywait
  );

endinterface

// File: rtl/dmem_access_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load extraction: picks the byte or half-word lane addressed by
// lane and sign- or zero-extends it according to the load funct3.
//   word    in  32  full memory word
//   lane    in  2   address[1:0] of the load
//   funct3  in  3   RV32 load funct3
//   result  out 32  extended load value (0 for reserved funct3)
// -----------------------------------------------------------------------------
module load_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = 32'h0000_0000;

    case (lane)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase

    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end

    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LW:   result = word;
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LHU:  result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MA-stage memory-access initiator. Turns RV32 loads/stores into word-aligned
// transactions on a word-only memory, doing read-modify-write for SB/SH,
// extracting/extending load data, rejecting misaligned or malformed requests
// and stalling the pipeline until each access has completed.
//   clock       in   1   rising-edge clock
//   reset       in   1   synchronous active-high reset
//   mem_read    in   4   [3] load request, [2:0] funct3
//   mem_write   in   3   [2] store request, [1:0] size
//   address     in   32  byte address
//   store_data  in   32  right-justified store value
//   load_data   out  32  extended load value, valid in DONE
//   stall       out  1   pipeline hold while an access is in flight
//   access_err  out  1   one-cycle error pulse in DONE
//   dmem        master port of dmem_access_ctrl_if
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_err,
  dmem_access_ctrl_if.master dmem
);

  state_t      state_r;
  logic [31:0] word_buf_r;
  logic        rmw_r;
  logic        access_err_r;
  logic [3:0]  dmem_read_r;
  logic [2:0]  dmem_write_r;
  logic [31:0] dmem_address_r;
  logic [31:0] dmem_writedata_r;

  logic        ld_req_s;
  logic        st_req_s;
  logic        err_s;
  logic [1:0]  size_s;
  logic [31:0] word_addr_s;
  logic [31:0] merged_s;
  logic [31:0] aligned_s;

  assign ld_req_s    = mem_read[3];
  assign st_req_s    = mem_write[2];
  assign size_s      = mem_write[1:0];
  assign word_addr_s = {address[31:2], 2'b00};

  // The merge works on the word arriving from memory so the write phase can
  // start on the same edge that ends the read phase.
  assign merged_s = merge_store(dmem.dmem_readdata, store_data, size_s, address[1:0]);

  load_align u_load_align (
    .word   (word_buf_r),
    .lane   (address[1:0]),
    .funct3 (mem_read[2:0]),
    .result (aligned_s)
  );

  // Request legality: alignment, reserved encodings, and load+store together
  always_comb begin
    err_s = 1'b0;
    if (ld_req_s && st_req_s) begin
      err_s = 1'b1;
    end else if (ld_req_s) begin
      case (mem_read[2:0])
        F3_LB, F3_LBU: err_s = 1'b0;
        F3_LH, F3_LHU: err_s = address[0];
        F3_LW:         err_s = |address[1:0];
        default:       err_s = 1'b1;
      endcase
    end else if (st_req_s) begin
      case (size_s)
        SZ_BYTE: err_s = 1'b0;
        SZ_HALF: err_s = address[0];
        SZ_WORD: err_s = |address[1:0];
        default: err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Access sequencing FSM with registered memory strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      word_buf_r       <= 32'h0000_0000;
      rmw_r            <= 1'b0;
      access_err_r     <= 1'b0;
      dmem_read_r      <= DMEM_RD_NONE;
      dmem_write_r     <= DMEM_WR_NONE;
      dmem_address_r   <= 32'h0000_0000;
      dmem_writedata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_req_s || st_req_s) begin
            if (err_s) begin
              // Rejected requests never touch memory.
              access_err_r <= 1'b1;
              state_r      <= DONE;
            end else if (ld_req_s) begin
              dmem_address_r <= word_addr_s;
              dmem_read_r    <= DMEM_RD_WORD;
              rmw_r          <= 1'b0;
              state_r        <= RD;
            end else if (size_s == SZ_WORD) begin
              dmem_address_r   <= word_addr_s;
              dmem_writedata_r <= store_data;
              dmem_write_r     <= DMEM_WR_WORD;
              rmw_r            <= 1'b0;
              state_r          <= WR;
            end else begin
              // Sub-word store: fetch the surrounding word first.
              dmem_address_r <= word_addr_s;
              dmem_read_r    <= DMEM_RD_WORD;
              rmw_r          <= 1'b1;
              state_r        <= RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        RD: begin
          if (!dmem.dmem_busywait) begin
            word_buf_r  <= dmem.dmem_readdata;
            dmem_read_r <= DMEM_RD_NONE;
            if (rmw_r) begin
              dmem_writedata_r <= merged_s;
              dmem_write_r     <= DMEM_WR_WORD;
              state_r          <= WR;
            end else begin
              state_r <= DONE;
            end
          end else begin
            state_r <= RD;
          end
        end

        WR: begin
          if (!dmem.dmem_busywait) begin
            dmem_write_r <= DMEM_WR_NONE;
            state_r      <= DONE;
          end else begin
            state_r <= WR;
          end
        end

        DONE: begin
          access_err_r <= 1'b0;
          rmw_r        <= 1'b0;
          state_r      <= IDLE;
        end

        default: begin
          dmem_read_r  <= DMEM_RD_NONE;
          dmem_write_r <= DMEM_WR_NONE;
          rmw_r        <= 1'b0;
          access_err_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // stall drops in DONE so the pipeline advances on the edge that leaves DONE.
  assign stall      = (ld_req_s | st_req_s) & (state_r != DONE);
  assign access_err = access_err_r;
  assign load_data  = ((state_r == DONE) && !access_err_r) ? aligned_s : 32'h0000_0000;

  assign dmem.dmem_read      = dmem_read_r;
  assign dmem.dmem_write     = dmem_write_r;
  assign dmem.dmem_address   = dmem_address_r;
  assign dmem.dmem_writedata = dmem_writedata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mem_read = 4'h0;
  logic [2:0]  mem_write = 3'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        stall;
  logic        access_err;

  dmem_access_ctrl_if dmem ();

  dmem_access_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .access_err (access_err),
    .dmem       (dmem)
  );

  always #5 clock = ~clock;

  // Request encodings
  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100;
  localparam logic [3:0] LHU = 4'b1101;
  localparam logic [2:0] SB  = 3'b100;
  localparam logic [2:0] SH  = 3'b101;
  localparam logic [2:0] SW  = 3'b110;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- memory device ----------------
  logic [31:0] mem [int];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          cfg_brd = 0;
  int          cfg_bwr = 0;
  int          rd_left = 0;
  int          wr_left = 0;
  logic        rd_seen = 1'b0;
  logic        wr_seen = 1'b0;
  logic        busy_at_edge = 1'b0;

  function automatic logic [31:0] mem_word(input int idx);
    return mem.exists(idx) ? mem[idx] : 32'h0;
  endfunction

  initial begin
    dmem.dmem_readdata = 32'h0;
    dmem.dmem_busywait = 1'b0;
    forever begin
      @(negedge clock);
      if (dmem.dmem_read[3]) begin
        dmem.dmem_readdata = mem_word(int'({2'b00, dmem.dmem_address[31:2]}));
        if (!rd_seen) rd_left = cfg_brd;
        rd_seen = 1'b1;
        if (rd_left > 0) begin dmem.dmem_busywait = 1'b1; rd_left--; end
        else dmem.dmem_busywait = 1'b0;
      end else if (dmem.dmem_write[2]) begin
        if (!wr_seen) wr_left = cfg_bwr;
        wr_seen = 1'b1;
        if (wr_left > 0) begin dmem.dmem_busywait = 1'b1; wr_left--; end
        else dmem.dmem_busywait = 1'b0;
      end else begin
        dmem.dmem_busywait = 1'b0;
      end
      if (!dmem.dmem_read[3]) rd_seen = 1'b0;
      if (!dmem.dmem_write[2]) wr_seen = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      busy_at_edge = dmem.dmem_busywait;
      if (dmem.dmem_read[3] && !dmem.dmem_busywait) rd_cnt++;
      if (dmem.dmem_write[2] && !dmem.dmem_busywait) begin
        mem[int'({2'b00, dmem.dmem_address[31:2]})] = dmem.dmem_writedata;
        wr_cnt++;
      end
    end
  end

  // ---------------- transaction expectations ----------------
  logic [31:0] ref_mem [int];
  int          cur_id = 0;
  int          done_id = 0;
  int          seen_id = 0;
  logic        txn_active = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  logic        exp_err = 1'b0;
  logic        exp_is_load = 1'b0;
  logic [31:0] exp_load = 32'h0;
  int          exp_stall = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  int          exp_idx = 0;
  logic [31:0] exp_word = 32'h0;
  int          base_rd = 0;
  int          base_wr = 0;
  int          stall_cnt = 0;
  logic [31:0] last_load = 32'h0;
  logic        last_err = 1'b0;
  int          last_stall = 0;
  logic [3:0]  snap_rd = 4'h0;
  logic [2:0]  snap_wr = 3'h0;
  logic [31:0] snap_addr = 32'h0;
  logic [31:0] snap_wdata = 32'h0;

  function automatic logic [31:0] ref_word(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        seen_id = seen_id;
      end else if (txn_active) begin
        if (seen_id != cur_id) begin
          seen_id   = cur_id;
          stall_cnt = 0;
        end
        if (stall) begin
          stall_cnt++;
          check("err_in_flight", 32'(access_err), 32'd0);
          if (dmem.dmem_read[3] || dmem.dmem_write[2])
            check("dmem_address", dmem.dmem_address, {cur_addr[31:2], 2'b00});
          if (dmem.dmem_read[3]) check("read_strobe", 32'(dmem.dmem_read), 32'hA);
          if (dmem.dmem_write[2]) check("write_strobe", 32'(dmem.dmem_write), 32'h6);
          if (busy_at_edge && (snap_rd[3] || snap_wr[2])) begin
            check("held_read", 32'(dmem.dmem_read), 32'(snap_rd));
            check("held_write", 32'(dmem.dmem_write), 32'(snap_wr));
            check("held_addr", dmem.dmem_address, snap_addr);
            check("held_wdata", dmem.dmem_writedata, snap_wdata);
          end
        end else if (done_id != cur_id) begin
          check("access_err", 32'(access_err), 32'(exp_err));
          if (exp_err || exp_is_load) check("load_data", load_data, exp_load);
          check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
          check("mem_reads", 32'(rd_cnt - base_rd), 32'(exp_rd));
          check("mem_writes", 32'(wr_cnt - base_wr), 32'(exp_wr));
          check("mem_word", mem_word(exp_idx), exp_word);
          last_load  = load_data;
          last_err   = access_err;
          last_stall = stall_cnt;
          done_id    = cur_id;
        end
      end else if (!(mem_read[3] || mem_write[2])) begin
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_read", 32'(dmem.dmem_read), 32'd0);
        check("idle_write", 32'(dmem.dmem_write), 32'd0);
        check("idle_err", 32'(access_err), 32'd0);
      end
      snap_rd    = dmem.dmem_read;
      snap_wr    = dmem.dmem_write;
      snap_addr  = dmem.dmem_address;
      snap_wdata = dmem.dmem_writedata;
    end
  end

  // ---------------- driver + reference model ----------------
  // Called at posedge+1 with the controller in IDLE; returns likewise.
  task automatic access(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                        input logic [31:0] sd, input int brd, input int bwr);
    logic        ld, st, err;
    logic [31:0] old, nw, v, mask;
    int          sh;
    bit          got;
    ld  = mr[3];
    st  = mw[2];
    err = 1'b0;
    if (ld && st) err = 1'b1;
    else if (ld) begin
      if (mr[2:0] == 3'b011 || mr[2:0] == 3'b110 || mr[2:0] == 3'b111) err = 1'b1;
      if ((mr[2:0] == 3'b001 || mr[2:0] == 3'b101) && a[0]) err = 1'b1;
      if (mr[2:0] == 3'b010 && a[1:0] != 2'b00) err = 1'b1;
    end else if (st) begin
      if (mw[1:0] == 2'b11) err = 1'b1;
      if (mw[1:0] == 2'b01 && a[0]) err = 1'b1;
      if (mw[1:0] == 2'b10 && a[1:0] != 2'b00) err = 1'b1;
    end
    old = ref_word(int'({2'b00, a[31:2]}));
    nw  = old;
    v   = 32'h0;
    if (!err && ld) begin
      if (mr[1:0] == 2'b00) begin
        v = (old >> (8 * int'(a[1:0]))) & 32'hFF;
        if (!mr[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (mr[1:0] == 2'b01) begin
        v = (old >> (16 * int'(a[1]))) & 32'hFFFF;
        if (!mr[2] && v[15]) v = v | 32'hFFFF_0000;
      end else v = old;
    end
    if (!err && st) begin
      if (mw[1:0] == 2'b10) nw = sd;
      else begin
        sh   = (mw[1:0] == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask = ((mw[1:0] == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        nw   = (old & ~mask) | ((sd << sh) & mask);
      end
      ref_mem[int'({2'b00, a[31:2]})] = nw;
    end
    exp_err     = err;
    exp_is_load = ld && !st;
    exp_load    = v;
    exp_idx     = int'({2'b00, a[31:2]});
    exp_word    = nw;
    if (err) begin exp_stall = 1; exp_rd = 0; exp_wr = 0; end
    else if (ld) begin exp_stall = 2 + brd; exp_rd = 1; exp_wr = 0; end
    else if (mw[1:0] == 2'b10) begin exp_stall = 2 + bwr; exp_rd = 0; exp_wr = 1; end
    else begin exp_stall = 3 + brd + bwr; exp_rd = 1; exp_wr = 1; end
    cfg_brd    = brd;
    cfg_bwr    = bwr;
    base_rd    = rd_cnt;
    base_wr    = wr_cnt;
    cur_addr   = a;
    cur_id     = cur_id + 1;
    txn_active = 1'b1;
    mem_read   = mr;
    mem_write  = mw;
    address    = a;
    store_data = sd;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      if (done_id == cur_id) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL timeout: access %0d never completed, got 0, expected 1", cur_id);
    end
    #1;
    mem_read   = 4'h0;
    mem_write  = 3'h0;
    txn_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved_word;
    int          saved_wr;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_dmem_read", 32'(dmem.dmem_read), 32'd0);
    check("rst_dmem_write", 32'(dmem.dmem_write), 32'd0);
    check("rst_dmem_address", dmem.dmem_address, 32'd0);
    check("rst_dmem_wdata", dmem.dmem_writedata, 32'd0);
    check("rst_access_err", 32'(access_err), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Loads with sign/zero extension
    access(4'h0, SW, 32'h40, 32'h8070_F1A2, 0, 0);
    access(LB, 3'h0, 32'h41, 32'h0, 0, 0);
    check("lb_literal", last_load, 32'hFFFF_FFF1);
    check("lb_stall_literal", 32'(last_stall), 32'd2);
    access(LBU, 3'h0, 32'h41, 32'h0, 0, 0);
    check("lbu_literal", last_load, 32'h0000_00F1);
    access(LH, 3'h0, 32'h42, 32'h0, 0, 0);
    check("lh_literal", last_load, 32'hFFFF_8070);
    access(LHU, 3'h0, 32'h40, 32'h0, 0, 0);
    check("lhu_literal", last_load, 32'h0000_F1A2);

    // Sub-word read-modify-write
    access(4'h0, SW, 32'h40, 32'h1122_3344, 0, 0);
    access(4'h0, SB, 32'h42, 32'h0000_00AB, 0, 0);
    check("sb_merge_literal", mem_word(16), 32'h11AB_3344);
    check("sb_stall_literal", 32'(last_stall), 32'd3);

    // Busywait in WR and RD phases
    access(4'h0, SW, 32'h10, 32'hDEAD_BEEF, 0, 3);
    check("sw_busy_stall_literal", 32'(last_stall), 32'd5);
    access(LW, 3'h0, 32'h10, 32'h0, 2, 0);
    access(4'h0, SH, 32'h12, 32'h0000_CAFE, 1, 1);
    access(LW, 3'h0, 32'h10, 32'h0, 0, 0);
    check("sh_merge_literal", last_load, 32'hCAFE_BEEF);

    // Rejected requests
    access(LH, 3'h0, 32'h13, 32'h0, 0, 0);
    check("lh_misaligned_err_literal", 32'(last_err), 32'd1);
    check("lh_misaligned_stall_literal", 32'(last_stall), 32'd1);
    access(LW, SW, 32'h40, 32'h5555_5555, 0, 0);
    check("both_req_err_literal", 32'(last_err), 32'd1);
    access(4'b1011, 3'h0, 32'h40, 32'h0, 0, 0);
    access(4'h0, 3'b111, 32'h40, 32'h0, 0, 0);
    access(4'h0, SW, 32'h42, 32'h0, 0, 0);
    access(LW, 3'h0, 32'h41, 32'h0, 0, 0);

    // Reset in the read phase of an SH abandons the store
    access(4'h0, SW, 32'h20, 32'hAABB_CCDD, 0, 0);
    saved_word = ref_word(8);
    saved_wr   = wr_cnt;
    cfg_brd    = 5;
    cfg_bwr    = 0;
    mem_write  = SH;
    address    = 32'h22;
    store_data = 32'h0000_5555;
    @(posedge clock);
    #1;
    check("rst_test_read_active", 32'(dmem.dmem_read), 32'hA);
    check("rst_test_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_read", 32'(dmem.dmem_read), 32'd0);
    check("rst_mid_write", 32'(dmem.dmem_write), 32'd0);
    check("rst_mid_address", dmem.dmem_address, 32'd0);
    reset     = 1'b0;
    mem_write = 3'h0;
    repeat (6) @(posedge clock);
    #1;
    check("rst_mem_unchanged", mem_word(8), saved_word);
    check("rst_no_write", 32'(wr_cnt - saved_wr), 32'd0);
    access(LW, 3'h0, 32'h20, 32'h0, 0, 0);
    check("rst_word_literal", last_load, 32'hAABB_CCDD);

    // Back-to-back loads
    access(4'h0, SW, 32'h0, 32'h0123_4567, 0, 0);
    access(4'h0, SW, 32'h4, 32'h89AB_CDEF, 0, 0);
    access(LW, 3'h0, 32'h0, 32'h0, 0, 0);
    check("b2b_first_literal", last_load, 32'h0123_4567);
    access(LW, 3'h0, 32'h4, 32'h0, 0, 0);
    check("b2b_second_literal", last_load, 32'h89AB_CDEF);
    check("b2b_second_stall", 32'(last_stall), 32'd2);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-access initiator for the MA stage: it sits between the pipeline's load/store controls and the word-only data memory. It converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned memory transactions, and performs read-modify-write for sub-word stores. It also extracts and sign- or zero-extends load data, checks alignment, and stalls the pipeline until each access completes.

## Interface
- No parameters; all widths are fixed at 32-bit address and data.
- clock  in  1  single clock for all state; everything updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- mem_read  in  4  [3] is the load request; [2:0] is funct3.
- mem_write  in  3  [2] is the store request; [1:0] is size: 00 byte, 01 half, 10 word.
- address  in  32  byte address from the ALU.
- store_data  in  32  rs2 value; the meaningful bits are right-justified.
- load_data  out  32  extended load result; valid only in DONE.
- stall  out  1  holds the pipeline while an access is in flight.
- access_err  out  1  one-cycle error pulse in DONE.
- dmem_read  out  4  memory read strobe; {1,010} when active, 0 when idle.
- dmem_write  out  3  memory write strobe; {1,10} when active, 0 when idle.
- dmem_address  out  32  word-aligned address, {address[31:2],2'b00}.
- dmem_writedata  out  32  full merged word.
- dmem_readdata  in  32  word returned by memory.
- dmem_busywait  in  1  memory not ready; the current phase is held.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE with no request:
  - Remain in IDLE.
  - All dmem strobes are 0.
- IDLE with a load:
  - Register the word address and dmem_read={1,010}.
  - Go to RD.
- IDLE with a word store:
  - Register dmem_writedata=store_data and dmem_write={1,10}.
  - Go to WR.
- IDLE with SB or SH:
  - Issue a word read first and go to RD.
  - Set the internal rmw flag.
- RD:
  - When dmem_busywait=0 at the edge, capture dmem_readdata into word_buf and clear dmem_read.
  - If rmw=0, go to DONE.
  - If rmw=1, merge store_data into word_buf:
    - SB: byte lane address[1:0].
    - SH: half lane address[1].
  - Drive dmem_writedata with the merged word and dmem_write={1,10}, then go to WR.
- WR: when dmem_busywait=0 at the edge, clear dmem_write and go to DONE.
- busywait=1 in RD or WR: stay in the state with the strobe, address and data held stable.
- DONE:
  - Output load_data from word_buf. LB/LBU select lane address[1:0]; LH/LHU select lane address[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Go to IDLE on the next edge.
- Errors go from IDLE straight to DONE with no memory access. In that DONE: access_err=1 and load_data=0.
  - Misaligned access: half with address[0]=1, or word with address[1:0]≠0.
  - Reserved load funct3: 011, 110, 111.
  - Store size 11.
  - mem_read[3] and mem_write[2] both set.
- stall = (mem_read[3] | mem_write[2]) & (state≠DONE). It is combinational.
- The pipeline holds mem_read, mem_write, address and store_data stable while stall=1.

## Timing
- Reset values for the edge with reset=1, applied regardless of state:
  - State goes to IDLE.
  - dmem_read=0, dmem_write=0, dmem_address=0, dmem_writedata=0.
  - word_buf=0, rmw=0, access_err=0.
- Because stall is combinational, it may be 1 during reset if a request is present.
- Reset mid-access abandons the access. Strobes drop at that edge, and any pending sub-word write is never issued.
- Cycle counts with busywait=0; each busywait cycle adds one cycle:

| Access | Sequence | Total cycles | Stall cycles |
|---|---|---|---|
| Load | IDLE, RD, DONE | 3 | 2 |
| Word store | IDLE, WR, DONE | 3 | 2 |
| Sub-word store | IDLE, RD, WR, DONE | 4 | 3 |
| Error | IDLE, DONE | 2 | 1 |

- dmem strobes are registered. They rise on the edge leaving IDLE and fall on the completing edge.
- Read data is sampled at the edge that ends RD. Memory updates readdata within RD, after the falling edge.
- A new request present in the cycle after DONE is accepted normally in IDLE, giving back-to-back accesses with no gap beyond IDLE.

## Structure
- Shared package `dmem_ctrl_pkg`:
  - State enum.
  - funct3 constants: LB, LH, LW, LBU, LHU.
  - Store size codes.
  - Memory strobe constants: DMEM_RD_WORD={1,010}, DMEM_WR_WORD={1,10}.
- Sub-module `load_align`:
  - Combinational lane select and sign/zero extension.
  - Inputs: word, address[1:0], funct3. Output: 32-bit result.
- The FSM, store merge and alignment check stay in the top module.

## Test plan
- Memory word 0x40 = 0x8070_F1A2, LB at 0x41 → one dmem read at 0x40, stall for 2 cycles, load_data=0xFFFF_FFF1. The same access as LBU → 0x0000_00F1.
- SB store_data=0x0000_00AB to 0x42, over word 0x1122_3344 → read then write. dmem_writedata=0x11AB_3344, 4 total cycles.
- SW 0xDEAD_BEEF at 0x10 with busywait held high for 3 cycles in WR → strobe, address and data stable throughout. Stall for 5 cycles.
- LH at 0x13 → no dmem strobe, access_err=1 for one cycle, load_data=0, stall for 1 cycle. A simultaneous load and store request gives the same response.
- Reset asserted in RD of an SH → at the next edge state=IDLE and all strobes are 0. Memory is unchanged.
- Back-to-back LW 0x0 then LW 0x4 → second dmem_read rises on the edge after DONE. Both values are returned correctly.
